fphub_mult_outbuf: RTL and testbench
====================================

// Module: fphub_mult_outbuf
// PURPOSE
//  Elastic result stage directly downstream of the combinational HUB multiplier.
//  - Captures each product Z, plus a caller tag, under valid/ready.
//  - Buffers results in a DEPTH-entry FIFO and classifies each word (zero / infinity / normal).
//  - Presents results to the consumer with backpressure, decoupling the multiplier from
//    the stalls of the next stage.
// PARAMETERS
//  M      23  mantissa width (implicit bit excluded; the ILSB is not stored)
//  E      8   exponent width; HUB bias = 2^(E-1)
//  TAG_W  4   width of the opaque sideband tag carried with each result
//  DEPTH  4   FIFO entries; must be a power of 2 and >= 2 (elaboration $error otherwise)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  flush      in   1            synchronous discard of all buffered entries
//  in_valid   in   1            multiplier result Z valid
//  in_ready   out  1            buffer can accept this cycle
//  in_z       in   E+M+1        HUB-format product {sign, exp[E-1:0], man[M-1:0]}
//  in_tag     in   TAG_W        sideband tag, travels with in_z
//  out_valid  out  1            head entry valid
//  out_ready  in   1            consumer accepts head entry
//  out_z      out  E+M+1        head result
//  out_tag    out  TAG_W        head tag
//  out_flags  out  2            {is_inf, is_zero} of head entry
//  level      out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): rd_ptr=wr_ptr=0, level=0, out_valid=0, in_ready=1,
//    out_z=0, out_tag=0, out_flags=0; storage array contents are don't-care.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both occur on the rising edge.
//  - in_ready = (level != DEPTH). No bypass: a push into an empty FIFO appears at the
//    output 1 cycle later (latency 1). in_ready depends only on state, not on out_ready.
//  - out_valid = (level != 0). out_z/out_tag/out_flags = storage[rd_ptr]; held stable while
//    out_valid & !out_ready. When out_valid=0, outputs are driven to 0.
//  - Classification is done at push and stored alongside the word:
//    - is_zero = (exp == 0);
//    - is_inf  = (exp == all ones);
//    - both 0 = normal. Sign is ignored for flags.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//  - Full: in_ready=0, so a same-cycle pop frees a slot for the next cycle only.
//  - Empty: pop cannot occur (out_valid=0); a push makes level=1 next cycle.
//  - flush=1: next state is empty (pointers and level = 0). flush overrides push and pop
//    in the same cycle; the in_z offered that cycle is dropped.
//  - Reset asserted mid-transfer: all entries are lost; no partial state is retained.
//  - Upstream contract: in_z/in_tag stable while in_valid & !in_ready. Dropping in_valid
//    without a handshake is legal.
// CONFIGURATION
//  FPHUB_OUTBUF_STATS_EN defined:
//    - Adds ports stat_clr (in, 1), zero_cnt (out, 16), inf_cnt (out, 16).
//    - Counters increment on each push whose class is zero / inf respectively.
//    - Counters saturate at 16'hFFFF.
//    - Counters reset to 0 on rst_n or on a synchronous stat_clr. stat_clr wins over an
//      increment in the same cycle.
//    - flush does not clear the counters.
//  Undefined: the ports and counters are absent; the FIFO behaviour is identical.
// STRUCTURE
//  - Shared package fphub_pkg:
//    - typedef enum logic [1:0] {HUB_NORMAL, HUB_ZERO, HUB_INF} hub_class_t;
//    - localparam-free function hub_exp_bias(E) returning 2^(E-1).
//  - Sub-module fphub_classify #(M,E): combinational in_z -> hub_class_t.
//    The other HUB stages reuse it.
//  - FIFO storage is an internal register array of {flags, tag, z}. No RAM macro is used.
// TESTING (M=23, E=8, TAG_W=4, DEPTH=4)
//  1. Reset, then push Z=32'h40000000 tag 3 with out_ready=1
//     -> out_valid next cycle; out_z=32'h40000000, out_tag=3, out_flags=2'b00; level 1 -> 0.
//  2. Push 32'h00000000, 32'h7F800000, 32'h80000000 with out_ready=0
//     -> head flags 01 stays stable while stalled; then 10, then 01 (negative zero); level=3.
//  3. Fill 4 entries with out_ready=0 -> in_ready=0, level=4. Hold in_valid
//     -> no 5th push. Pulse out_ready one cycle -> in_ready=1 the following cycle.
//  4. Stream 12 words, tags 0..11, with random out_ready
//     -> tags emerge in order 0..11 with no loss or duplication (pointer wrap covered).
//  5. level=3, then assert flush with in_valid=1 the same cycle
//     -> next cycle level=0, out_valid=0, the offered word is dropped.
//     Assert rst_n=0 mid-stream -> outputs zero immediately, without waiting for clk.
//  6. (STATS_EN) Push 3 zeros and 2 infinities -> zero_cnt=3, inf_cnt=2.
//     stat_clr -> both 0. Force zero_cnt to 16'hFFFF and push a zero -> it stays 16'hFFFF.

Source files
------------

// File: rtl/fphub_pkg.sv
// -----------------------------------------------------------------------------
// fphub_pkg
// Shared types and helpers for the HUB floating-point stages.
//   hub_class_t   : classification of a HUB word (normal / zero / infinity)
//   hub_exp_bias  : HUB exponent bias, 2^(E-1), for an E-bit exponent
// -----------------------------------------------------------------------------
package fphub_pkg;

    typedef enum logic [1:0] {
        HUB_NORMAL = 2'd0,
        HUB_ZERO   = 2'd1,
        HUB_INF    = 2'd2
    } hub_class_t;

    function automatic int hub_exp_bias(input int e);
        return 1 << (e - 1);
    endfunction

endpackage

// File: rtl/fphub_classify.sv
// -----------------------------------------------------------------------------
// fphub_classify
// Combinational classifier for a HUB-format word {sign, exp, man}.
// The sign and mantissa do not take part: a zero exponent means zero,
// an all-ones exponent means infinity, anything else is normal.
// Parameters: M (mantissa width), E (exponent width).
// Ports:
//   z    in   E+M+1   HUB word
//   cls  out  2       hub_class_t of z
// -----------------------------------------------------------------------------
module fphub_classify
    import fphub_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic [E+M:0] z,
    output hub_class_t   cls
);

    // All-ones exponent expressed through the bias: 2*2^(E-1) - 1.
    localparam logic [E-1:0] EXP_ALL_ONES = E'(2 * hub_exp_bias(E) - 1);

    logic [E-1:0] exp_field;
    logic         unused_bits;

    assign exp_field   = z[E+M-1:M];
    assign unused_bits = ^{z[E+M], z[M-1:0]};

    always_comb begin
        cls = HUB_NORMAL;
        if (exp_field == '0) begin
            cls = HUB_ZERO;
        end else if (exp_field == EXP_ALL_ONES) begin
            cls = HUB_INF;
        end
    end

endmodule

// File: rtl/fphub_mult_outbuf.sv
// -----------------------------------------------------------------------------
// fphub_mult_outbuf
// Elastic result buffer behind the combinational HUB multiplier. Each accepted
// product is classified on entry and stored with its tag in a DEPTH-entry
// register FIFO; the head entry is presented with valid/ready backpressure.
// A push into an empty buffer is visible one cycle later (no bypass).
// Optional feature macro: FPHUB_OUTBUF_STATS_EN adds saturating zero/inf
// counters with a synchronous clear (stat_clr); flush leaves them untouched.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous discard of all entries (beats push/pop)
//   in_valid/in_ready    upstream handshake; in_ready = not full
//   in_z, in_tag         product {sign, exp, man} and sideband tag
//   out_valid/out_ready  downstream handshake; out_valid = not empty
//   out_z, out_tag       head entry (zero when out_valid is low)
//   out_flags            {is_inf, is_zero} of the head entry
//   level                occupancy
//   stat_clr, zero_cnt, inf_cnt   (FPHUB_OUTBUF_STATS_EN only)
// -----------------------------------------------------------------------------
module fphub_mult_outbuf
    import fphub_pkg::*;
#(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [E+M:0]               in_z,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [E+M:0]               out_z,
    output logic [TAG_W-1:0]           out_tag,
    output logic [1:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef FPHUB_OUTBUF_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [15:0]                zero_cnt,
    output logic [15:0]                inf_cnt
`endif
);

    localparam int ZW    = E + M + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int ENT_W = 2 + TAG_W + ZW;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fphub_mult_outbuf: DEPTH must be a power of 2 and >= 2");
    end

    hub_class_t       in_cls;
    logic [1:0]       in_flags;
    logic             push;
    logic             pop;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [1:0]       head_flags;
    logic [TAG_W-1:0] head_tag;
    logic [ZW-1:0]    head_z;

    fphub_classify #(.M(M), .E(E)) u_classify (
        .z   (in_z),
        .cls (in_cls)
    );

    always_comb begin
        in_flags = 2'b00;
        case (in_cls)
            HUB_ZERO: in_flags = 2'b01;
            HUB_INF:  in_flags = 2'b10;
            default:  in_flags = 2'b00;
        endcase
    end

    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Control state: pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_flags, in_tag, in_z};
        end
    end

    assign {head_flags, head_tag, head_z} = mem[rd_ptr];

    assign out_z     = out_valid ? head_z     : '0;
    assign out_tag   = out_valid ? head_tag   : '0;
    assign out_flags = out_valid ? head_flags : 2'b00;

`ifdef FPHUB_OUTBUF_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only words that actually enter the buffer are counted; a push that a
    // same-cycle flush discards is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= '0;
            inf_cnt  <= '0;
        end else if (stat_clr) begin
            zero_cnt <= '0;
            inf_cnt  <= '0;
        end else if (push && !flush) begin
            if (in_cls == HUB_ZERO) zero_cnt <= sat_inc(zero_cnt);
            if (in_cls == HUB_INF)  inf_cnt  <= sat_inc(inf_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fphub_mult_outbuf.sv
module tb_fphub_mult_outbuf;

    localparam int M = 23, E = 8, TAG_W = 4, DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_z;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [3:0]  out_tag;
    logic [1:0]  out_flags;
    logic [2:0]  level;
`ifdef FPHUB_OUTBUF_STATS_EN
    logic        stat_clr;
    logic [15:0] zero_cnt;
    logic [15:0] inf_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    fphub_mult_outbuf #(.M(M), .E(E), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .out_flags (out_flags),
        .level     (level)
`ifdef FPHUB_OUTBUF_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .zero_cnt  (zero_cnt),
        .inf_cnt   (inf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags straight from the word's exponent value.
    function automatic logic [1:0] ref_flags(input logic [31:0] z);
        int e;
        e = int'(z[30:23]);
        if (e == 255) return 2'b10;
        if (e == 0)   return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_z();
        logic [31:0] z;
        int k;
        z = $urandom;
        k = $urandom_range(0, 3);
        if (k == 0) z[30:23] = 8'h00;
        if (k == 1) z[30:23] = 8'hFF;
        return z;
    endfunction

    // Reference model: a FIFO queue of accepted {z, tag}.
    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
    } ent_t;

    ent_t q[$];
    int   popped[$];
    bit   m_push, m_pop;
    ent_t m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) begin
                    popped.push_back(int'(q[0].tag));
                    q.delete(0);
                end
                if (m_push) begin
                    m_e.z   = in_z;
                    m_e.tag = in_tag;
                    q.push_back(m_e);
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("m_in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
            chk("m_level",     64'(level),     64'(q.size()));
            if (q.size() != 0) begin
                chk("m_out_z",     64'(out_z),     64'(q[0].z));
                chk("m_out_tag",   64'(out_tag),   64'(q[0].tag));
                chk("m_out_flags", 64'(out_flags), 64'(ref_flags(q[0].z)));
            end else begin
                chk("m_idle_z",     64'(out_z),     64'd0);
                chk("m_idle_tag",   64'(out_tag),   64'd0);
                chk("m_idle_flags", 64'(out_flags), 64'd0);
            end
        end
    end

    // Drive one cycle's inputs, then return at 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [31:0] z, input logic [3:0] t,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_z      = z;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] z5;
        logic [31:0] zs;
        int          i;
        int          budget;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_z = '0; in_tag = '0; out_ready = 1'b0;
`ifdef FPHUB_OUTBUF_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_en = 1'b1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_level",     64'(level),     64'd0);
        chk("rst_out_z",     64'(out_z),     64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);

        // 1: single word, latency 1
        cyc(1'b1, 32'h40000000, 4'd3, 1'b1, 1'b0);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_z",     64'(out_z),     64'h40000000);
        chk("t1_out_tag",   64'(out_tag),   64'd3);
        chk("t1_out_flags", 64'(out_flags), 64'd0);
        chk("t1_level",     64'(level),     64'd1);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t1_level0",    64'(level),     64'd0);
        chk("t1_valid0",    64'(out_valid), 64'd0);

        // 2: zero / inf / negative zero under stall
        cyc(1'b1, 32'h00000000, 4'd1, 1'b0, 1'b0);
        chk("t2_flags_a", 64'(out_flags), 64'b01);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        chk("t2_flags_hold", 64'(out_flags), 64'b01);
        cyc(1'b1, 32'h7F800000, 4'd2, 1'b0, 1'b0);
        cyc(1'b1, 32'h80000000, 4'd3, 1'b0, 1'b0);
        chk("t2_level3",  64'(level),     64'd3);
        chk("t2_flags_b", 64'(out_flags), 64'b01);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t2_flags_inf", 64'(out_flags), 64'b10);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t2_flags_nz", 64'(out_flags), 64'b01);
        chk("t2_z_nz",     64'(out_z),     64'h80000000);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t2_empty", 64'(level), 64'd0);

        // 3: fill, hold, single pop
        for (int k = 0; k < 4; k++) cyc(1'b1, rand_z(), 4'(k), 1'b0, 1'b0);
        chk("t3_full_rdy", 64'(in_ready), 64'd0);
        chk("t3_full_lvl", 64'(level),    64'd4);
        z5 = rand_z();
        cyc(1'b1, z5, 4'd4, 1'b0, 1'b0);
        cyc(1'b1, z5, 4'd4, 1'b0, 1'b0);
        chk("t3_no_5th", 64'(level), 64'd4);
        cyc(1'b1, z5, 4'd4, 1'b1, 1'b0);
        chk("t3_pop_lvl", 64'(level),    64'd3);
        chk("t3_pop_rdy", 64'(in_ready), 64'd1);
        cyc(1'b1, z5, 4'd4, 1'b0, 1'b0);
        chk("t3_refill", 64'(level), 64'd4);
        for (int k = 0; k < 5; k++) cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t3_drained", 64'(level), 64'd0);

        // 4: random stream, tags 0..11
        popped.delete();
        i = 0;
        budget = 0;
        zs = rand_z();
        while (i < 12 && budget < 400) begin
            if (in_ready) begin
                cyc(1'b1, zs, 4'(i), 1'($urandom_range(0, 1)), 1'b0);
                i++;
                zs = rand_z();
            end else begin
                cyc(1'b1, zs, 4'(i), 1'($urandom_range(0, 1)), 1'b0);
            end
            budget++;
        end
        chk("t4_push_budget", 64'(i), 64'd12);
        budget = 0;
        while (level != 0 && budget < 50) begin
            cyc(1'b0, 32'h0, 4'd0, 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        chk("t4_drain_budget", 64'(level), 64'd0);
        chk("t4_count", 64'(popped.size()), 64'd12);
        for (int k = 0; k < popped.size(); k++) chk("t4_order", 64'(popped[k]), 64'(k));

        // 5: flush beats a same-cycle push, then asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) cyc(1'b1, rand_z(), 4'(k), 1'b0, 1'b0);
        chk("t5_level3", 64'(level), 64'd3);
        cyc(1'b1, 32'h3F800000, 4'd9, 1'b0, 1'b1);
        chk("t5_flush_lvl", 64'(level),     64'd0);
        chk("t5_flush_vld", 64'(out_valid), 64'd0);
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        chk("t5_dropped", 64'(level), 64'd0);
        cyc(1'b1, 32'h3F800000, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 32'h40400000, 4'd2, 1'b0, 1'b0);
        chk("t5_pre_rst", 64'(level), 64'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 64'(out_valid), 64'd0);
        chk("t5_rst_z",   64'(out_z),     64'd0);
        chk("t5_rst_tag", 64'(out_tag),   64'd0);
        chk("t5_rst_lvl", 64'(level),     64'd0);
        chk("t5_rst_rdy", 64'(in_ready),  64'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        chk("t5_after_rst", 64'(level), 64'd0);

`ifdef FPHUB_OUTBUF_STATS_EN
        // 6: statistics counters
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h00000000, 4'(k), 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b1, 32'hFF800000, 4'(k), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t6_zero_cnt", 64'(zero_cnt), 64'd3);
        chk("t6_inf_cnt",  64'(inf_cnt),  64'd2);
        stat_clr = 1'b1;
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        stat_clr = 1'b0;
        chk("t6_clr_zero", 64'(zero_cnt), 64'd0);
        chk("t6_clr_inf",  64'(inf_cnt),  64'd0);
        force dut.zero_cnt = 16'hFFFF;
        #1;
        release dut.zero_cnt;
        cyc(1'b1, 32'h00000000, 4'd5, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        chk("t6_sat", 64'(zero_cnt), 64'hFFFF);
        chk("t6_sat_inf", 64'(inf_cnt), 64'd0);
`endif

        @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
